stream_window_decoder: RTL and testbench

//  Downstream of a neuron layer: converts each of NEURON_COUNT stochastic output

---
 rtl/stream_window_decoder.sv | 143 ++++++++++++++
 tb/tb_stream_window_decoder.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_window_decoder.sv
// stream_window_decoder
// Turns NEURON_COUNT stochastic bitstreams into binary counts by summing ones
// over a window of 2**WINDOW_LOG2 cycles. Finished results are held and offered
// on a valid/ready handshake.
// Build option: define STREAM_DECODER_BIPOLAR_EN to report each lane as the
// signed value 2*ones - W instead of the plain ones count.
//
// state | meaning
// IDLE  | waiting for start
// ACCUM | sampling stream_in, one sample per cycle, W samples total
// HOLD  | result_count valid, waiting for result_ready
module stream_window_decoder #(
  parameter int NEURON_COUNT = 2,
  parameter int WINDOW_LOG2  = 8,
`ifdef STREAM_DECODER_BIPOLAR_EN
  localparam int CW = WINDOW_LOG2 + 2
`else
  localparam int CW = WINDOW_LOG2 + 1
`endif
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic                       start,
  input  logic [NEURON_COUNT-1:0]    stream_in,
  output logic                       busy,
  output logic                       result_valid,
  input  logic                       result_ready,
  output logic [NEURON_COUNT*CW-1:0] result_count
);

  localparam int AW = WINDOW_LOG2 + 1;
  localparam logic [WINDOW_LOG2-1:0] CNT_ONE = WINDOW_LOG2'(1);
`ifdef STREAM_DECODER_BIPOLAR_EN
  localparam logic [CW-1:0] W_VAL = CW'(2 ** WINDOW_LOG2);
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Down-counter: loaded with W-1 at window start, the sample taken while it
  // reads zero is sample W and closes the window.
  logic [WINDOW_LOG2-1:0] win_cnt;
  logic [AW-1:0]          acc     [NEURON_COUNT];
  logic [AW-1:0]          sum     [NEURON_COUNT];
  logic [NEURON_COUNT*CW-1:0] res_nxt;
  logic                   clr_win;
  logic                   take_sample;
  logic                   load_res;

  // State register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and datapath strobes
  always_comb begin
    state_nxt   = state;
    clr_win     = 1'b0;
    take_sample = 1'b0;
    load_res    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = ACCUM;
          clr_win   = 1'b1;
        end
      end
      ACCUM: begin
        take_sample = 1'b1;
        if (win_cnt == '0) begin
          state_nxt = HOLD;
          load_res  = 1'b1;
        end
      end
      HOLD: begin
        if (result_ready) begin
          if (start) begin
            state_nxt = ACCUM;
            clr_win   = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy         = (state == ACCUM);
  assign result_valid = (state == HOLD);

  // Lane totals including the current sample; also the value latched at window end
  always_comb begin
    res_nxt = '0;
    for (int i = 0; i < NEURON_COUNT; i++) begin
      sum[i] = acc[i] + {{WINDOW_LOG2{1'b0}}, stream_in[i]};
`ifdef STREAM_DECODER_BIPOLAR_EN
      res_nxt[i*CW +: CW] = {sum[i], 1'b0} - W_VAL;
`else
      res_nxt[i*CW +: CW] = sum[i];
`endif
    end
  end

  // Window counter and per-lane accumulators
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      win_cnt <= '0;
      for (int i = 0; i < NEURON_COUNT; i++) begin
        acc[i] <= '0;
      end
    end else if (clr_win) begin
      win_cnt <= '1;
      for (int i = 0; i < NEURON_COUNT; i++) begin
        acc[i] <= '0;
      end
    end else if (take_sample) begin
      win_cnt <= win_cnt - CNT_ONE;
      for (int i = 0; i < NEURON_COUNT; i++) begin
        acc[i] <= sum[i];
      end
    end
  end

  // Result holding register, written only when a window closes
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      result_count <= '0;
    end else if (load_res) begin
      result_count <= res_nxt;
    end
  end

endmodule

// File: tb/tb_stream_window_decoder.sv
// Directed bench for stream_window_decoder: a W=16, 2-lane instance for the
// main scenarios and a W=4, 4-lane instance for lane packing.
module tb_stream_window_decoder;

  localparam int NC = 2;
  localparam int WL = 4;
  localparam int W  = 16;
`ifdef STREAM_DECODER_BIPOLAR_EN
  localparam int CW  = WL + 2;
  localparam int CW4 = 4;
  localparam bit BIP = 1'b1;
`else
  localparam int CW  = WL + 1;
  localparam int CW4 = 3;
  localparam bit BIP = 1'b0;
`endif

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic start = 1'b0;
  logic result_ready = 1'b0;
  logic [NC-1:0] stream_in = '0;
  logic busy;
  logic result_valid;
  logic [NC*CW-1:0] result_count;

  logic start4 = 1'b0;
  logic result_ready4 = 1'b0;
  logic [3:0] stream_in4 = '0;
  logic busy4;
  logic result_valid4;
  logic [4*CW4-1:0] result_count4;

  int checks = 0;
  int errors = 0;

  stream_window_decoder #(.NEURON_COUNT(NC), .WINDOW_LOG2(WL)) u_dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .start        (start),
    .stream_in    (stream_in),
    .busy         (busy),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result_count (result_count)
  );

  stream_window_decoder #(.NEURON_COUNT(4), .WINDOW_LOG2(2)) u_dut4 (
    .clk          (clk),
    .n_rst        (n_rst),
    .start        (start4),
    .stream_in    (stream_in4),
    .busy         (busy4),
    .result_valid (result_valid4),
    .result_ready (result_ready4),
    .result_count (result_count4)
  );

  always #5 clk = ~clk;

  function automatic int expv(input int ones, input int w);
    return BIP ? (2 * ones - w) : ones;
  endfunction

  function automatic logic [NC*CW-1:0] pack2(input int ones0, input int ones1);
    logic [NC*CW-1:0] v;
    v = '0;
    v[0 +: CW]  = CW'(expv(ones0, W));
    v[CW +: CW] = CW'(expv(ones1, W));
    return v;
  endfunction

  // Drives one window on the main instance; sample k uses bit k-1 of p0/p1.
  task automatic run_window(input logic [15:0] p0, input logic [15:0] p1,
                            input logic rdy, input logic poke,
                            output int busy_cnt, output int lat);
    int idx;
    @(negedge clk);
    start = 1'b1;
    result_ready = rdy;
    stream_in = '0;
    lat = 0;
    busy_cnt = 0;
    do begin
      @(negedge clk);
      lat++;
      if (busy) busy_cnt++;
      start = poke && (lat == 5 || lat == 10);
      idx = (lat <= 16) ? lat - 1 : 0;
      stream_in = (lat <= 16) ? {p1[idx], p0[idx]} : 2'b00;
    end while (!result_valid && lat < 40);
    start = 1'b0;
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    #2;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++;
    if (result_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", result_valid); end
    checks++;
    if (result_count !== '0) begin errors++; $display("FAIL reset_count got %h want 0", result_count); end
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  task automatic test_constant();
    int b, lat;
    run_window(16'hFFFF, 16'h0000, 1'b1, 1'b0, b, lat);
    checks++;
    if (lat !== 17) begin errors++; $display("FAIL const_latency got %0d want 17", lat); end
    checks++;
    if (result_count !== pack2(16, 0)) begin
      errors++; $display("FAIL const_lanes got %h want %h", result_count, pack2(16, 0));
    end
    @(negedge clk);
    checks++;
    if (result_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL const_one_cycle got valid=%b busy=%b want 0 0", result_valid, busy);
    end
    result_ready = 1'b0;
  endtask

  task automatic test_pattern();
    int b, lat;
    run_window(16'h5555, 16'h1111, 1'b0, 1'b0, b, lat);
    checks++;
    if (b !== 16) begin errors++; $display("FAIL pattern_busy_cycles got %0d want 16", b); end
    checks++;
    if (result_count !== pack2(8, 4)) begin
      errors++; $display("FAIL pattern_lanes got %h want %h", result_count, pack2(8, 4));
    end
    result_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (result_valid !== 1'b0) begin errors++; $display("FAIL pattern_release got %b want 0", result_valid); end
    result_ready = 1'b0;
  endtask

  task automatic test_hold();
    int b, lat;
    int bad;
    run_window(16'hFFFF, 16'hFFFF, 1'b0, 1'b1, b, lat);
    checks++;
    if (lat !== 17 || b !== 16) begin
      errors++; $display("FAIL hold_no_restart got lat=%0d busy=%0d want 17 16", lat, b);
    end
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      start = (c % 2 == 0);
      @(negedge clk);
      checks++;
      if (result_valid !== 1'b1 || busy !== 1'b0 || result_count !== pack2(16, 16)) begin
        errors++;
        $display("FAIL hold_stable cycle %0d got valid=%b busy=%b count=%h want 1 0 %h",
                 c, result_valid, busy, result_count, pack2(16, 16));
      end
    end
    start = 1'b0;
    result_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (result_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL hold_release got valid=%b busy=%b want 0 0", result_valid, busy);
    end
    result_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int bc;
    bc = 0;
    @(negedge clk);
    start = 1'b1;
    result_ready = 1'b1;
    stream_in = 2'b01;
    for (int c = 1; c <= 34; c++) begin
      @(negedge clk);
      if (busy) bc++;
      if (c == 17) begin
        stream_in = 2'b10;
        checks++;
        if (result_valid !== 1'b1 || result_count !== pack2(16, 0)) begin
          errors++; $display("FAIL b2b_first got valid=%b count=%h want 1 %h",
                             result_valid, result_count, pack2(16, 0));
        end
      end
      if (c == 18) begin
        checks++;
        if (result_valid !== 1'b0 || busy !== 1'b1) begin
          errors++; $display("FAIL b2b_no_idle got valid=%b busy=%b want 0 1", result_valid, busy);
        end
      end
      if (c == 34) begin
        checks++;
        if (result_valid !== 1'b1 || result_count !== pack2(0, 16)) begin
          errors++; $display("FAIL b2b_second got valid=%b count=%h want 1 %h",
                             result_valid, result_count, pack2(0, 16));
        end
      end
    end
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (bc !== 32) begin errors++; $display("FAIL b2b_busy_cycles got %0d want 32", bc); end
    checks++;
    if (result_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL b2b_end got valid=%b busy=%b want 0 0", result_valid, busy);
    end
    result_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int b, lat;
    @(negedge clk);
    start = 1'b1;
    result_ready = 1'b0;
    stream_in = 2'b11;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL abort_pre_busy got %b want 1", busy); end
    n_rst = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || result_valid !== 1'b0 || result_count !== '0) begin
      errors++; $display("FAIL abort_outputs got busy=%b valid=%b count=%h want 0 0 0",
                         busy, result_valid, result_count);
    end
    @(negedge clk);
    n_rst = 1'b1;
    run_window(16'hFFFF, 16'h00FF, 1'b1, 1'b0, b, lat);
    checks++;
    if (lat !== 17 || b !== 16) begin
      errors++; $display("FAIL abort_fresh_timing got lat=%0d busy=%0d want 17 16", lat, b);
    end
    checks++;
    if (result_count !== pack2(16, 8)) begin
      errors++; $display("FAIL abort_fresh_lanes got %h want %h", result_count, pack2(16, 8));
    end
    @(negedge clk);
    result_ready = 1'b0;
  endtask

  task automatic test_wide_lanes();
    logic [3:0] pats [2];
    logic [4*CW4-1:0] exp4;
    int lat;
    pats[0] = 4'b1111;
    pats[1] = 4'b0101;
    result_ready4 = 1'b1;
    for (int p = 0; p < 2; p++) begin
      @(negedge clk);
      start4 = 1'b1;
      stream_in4 = pats[p];
      lat = 0;
      do begin
        @(negedge clk);
        lat++;
        start4 = 1'b0;
      end while (!result_valid4 && lat < 20);
      exp4 = '0;
      for (int i = 0; i < 4; i++) begin
        exp4[i*CW4 +: CW4] = CW4'(expv(pats[p][i] ? 4 : 0, 4));
      end
      checks++;
      if (lat !== 5) begin errors++; $display("FAIL wide_latency pat %0d got %0d want 5", p, lat); end
      checks++;
      if (result_count4 !== exp4) begin
        errors++; $display("FAIL wide_lanes pat %0d got %h want %h", p, result_count4, exp4);
      end
    end
    @(negedge clk);
    result_ready4 = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_constant();
    test_pattern();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    test_wide_lanes();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
